pe_align_add: RTL
=================

PE_ALIGN_ADD -- requirements
Module: pe_align_add

Interface
REQ-001 SHALL take widths from config_sys.vh, not module parameters: MANTISSA, 23, stored fraction bits (M); EXPONENT, 8, exponent bits (E).
REQ-002 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports in_valid (input, 1) and in_ready (output, 1), forming the upstream handshake.
REQ-005 SHALL have ports sign_a, sign_b (input, 1 each): operand signs.
REQ-006 SHALL have ports exp_a, exp_b (input, E each): biased exponents.
REQ-007 SHALL have ports sig_a, sig_b (input, M+1 each): significands, hidden bit explicit at [M].
REQ-008 SHALL have port sub_op, input, 1: 1 = compute a-b, 0 = compute a+b.
REQ-009 SHALL have ports out_valid (output, 1) and out_ready (input, 1), forming the downstream handshake.
REQ-010 SHALL have outputs sign_out (1), exp_out (E), sig_out (M+1), zero_out (1) and sticky_out (1): an unnormalized result for the leading-zero normalizer.

Function
REQ-011 SHALL be a 2-stage pipeline, S1 align then S2 add; latency is exactly 2 cycles from in_valid&in_ready to out_valid when unstalled; throughput is 1 per cycle.
REQ-012 SHALL advance a stage only when it is empty or its successor advances; in_ready = !s1_valid | s1_advance; the out_* bundle SHALL be held stable while out_valid&!out_ready.
REQ-013 SHALL have S1 form eff_sign_b = sign_b^sub_op and eff_sub = sign_a^eff_sign_b.
REQ-014 SHALL have S1 select big = b if exp_b>exp_a, or if exponents are equal and sig_b>sig_a; otherwise big = a.
REQ-015 SHALL have S1 shift the small significand right by d = exp_big-exp_small; if d>M+1, shifted = 0.
REQ-016 SHALL have S1 compute raw_sticky = OR of all bits shifted out, including the whole small significand when d>M+1.
REQ-017 SHALL, in S2 for effective add, compute an (M+2)-bit sum; on carry, sig_out = sum[M+1:1], exp_out = exp_big+1 saturating at all-ones, sticky includes sum[0]; otherwise sig_out = sum[M:0], exp_out = exp_big.
REQ-018 SHALL, in S2 for effective subtract, output big-shifted (never negative) with exp_out = exp_big; leading zeros are left for the downstream normalizer.
REQ-019 SHALL set sign_out to the sign of big, using eff_sign_b when big is b.
REQ-020 SHALL, on an exact zero result, drive zero_out=1, sign_out=0, exp_out=0 and sig_out=0.
REQ-021 SHALL pass both operands unchanged through alignment when they are equal in exponent, i.e. d=0.

Reset
REQ-022 SHALL, on rst_n low, immediately clear s1_valid, s2_valid and out_valid, and drive all out_* data to 0 and in_ready to 1 after release.
REQ-023 SHALL discard in-flight transactions on reset mid-operation and not replay them.

Configuration
REQ-024 SHALL, with PE_ALIGN_STICKY_EN defined, carry raw_sticky through S1/S2 to sticky_out.
REQ-025 SHALL, without PE_ALIGN_STICKY_EN, tie sticky_out to 0 and synthesize no sticky OR-tree or pipeline bit.

Structure
REQ-026 SHALL take M and E solely from config_sys.vh; the shared stage-bundle field widths (sign, E, M+1) SHALL also be defined there.
REQ-027 SHALL place the alignment barrel shifter plus sticky reduction in sub-module pe_align_shift, which is combinational and instantiated once in S1.

Verification (M=23, E=8)
REQ-028 SHALL verify that a=b={0,127,0x800000} with sub_op=0 gives, 2 cycles later, sig_out=0x800000, exp_out=128, sign_out=0, zero_out=0.
REQ-029 SHALL verify that a={0,127,0xC00000}, b={0,127,0x800000} with sub_op=1 gives sig_out=0x400000, exp_out=127, sign_out=0.
REQ-030 SHALL verify that a={0,150,0x800000}, b={0,100,0x800001} gives sig_out=0x800000 and exp_out=150; sticky_out=1 with the macro and 0 without.
REQ-031 SHALL verify that a equal to b with sub_op=1 gives zero_out=1 and sign_out=0, exp_out=0, sig_out=0.
REQ-032 SHALL verify that with out_ready low for 5 cycles and 4 back-to-back inputs, exactly 2 are accepted, in_ready=0 thereafter, and outputs are in order with no loss or duplication.
REQ-033 SHALL verify that asserting rst_n low with both stages full gives out_valid=0 in the same cycle, no stale output after release, and the first post-reset result correct.

Source files
------------

// File: rtl/pe_align_add_pkg.sv
// ---------------------------------------------------------------------------
// pe_align_add_pkg
// Shared types for the align/add pipeline. All widths come from config_sys.vh.
// Optional feature macro: PE_ALIGN_STICKY_EN adds a sticky bit to the stage
// bundles; without it the bundles carry no sticky state at all.
// ---------------------------------------------------------------------------
package pe_align_add_pkg;

`include "config_sys.vh"

   localparam int M      = `MANTISSA;
   localparam int E      = `EXPONENT;
   localparam int SIGN_W = `PE_SIGN_W;
   localparam int EXP_W  = `PE_EXP_W;
   localparam int SIG_W  = `PE_SIG_W;

   // Effective operation after folding sub_op into the sign of b
   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } opKind_e;

   // Aligned operands held between the align stage and the add stage
   typedef struct packed {
      logic [SIGN_W-1:0] sign;
      logic [EXP_W-1:0]  exp;
      logic [SIG_W-1:0]  bigSig;
      logic [SIG_W-1:0]  smallSig;
      opKind_e           op;
`ifdef PE_ALIGN_STICKY_EN
      logic              sticky;
`endif
   } s1Bundle_t;

   // Unnormalized result handed to the leading-zero normalizer
   typedef struct packed {
      logic [SIGN_W-1:0] sign;
      logic [EXP_W-1:0]  exp;
      logic [SIG_W-1:0]  sig;
      logic              zero;
`ifdef PE_ALIGN_STICKY_EN
      logic              sticky;
`endif
   } outBundle_t;

   // Exponent increment after a carry-out; an all-ones exponent stays put
   function automatic logic [EXP_W-1:0] expIncSat(input logic [EXP_W-1:0] e);
      return (&e) ? e : e + 1'b1;
   endfunction

endpackage

// File: rtl/config_sys.vh
// ---------------------------------------------------------------------------
// config_sys.vh
// System-wide floating-point widths shared by the alignment/add datapath.
// MANTISSA is the stored fraction width, EXPONENT the biased exponent width.
// The PE_* widths describe the fields of the stage bundles passed between
// pipeline stages (sign, exponent, significand with explicit hidden bit).
// ---------------------------------------------------------------------------
`ifndef CONFIG_SYS_VH
`define CONFIG_SYS_VH

`define MANTISSA  23
`define EXPONENT  8

`define PE_SIGN_W 1
`define PE_EXP_W  `EXPONENT
`define PE_SIG_W  (`MANTISSA + 1)

`endif

// File: rtl/pe_align_shift.sv
// ---------------------------------------------------------------------------
// pe_align_shift
// Combinational alignment barrel shifter. Shifts the smaller significand
// right by the exponent difference; distances beyond the significand width
// flush it to zero. With PE_ALIGN_STICKY_EN it also reports the OR of every
// bit shifted out, so rounding downstream still sees the lost precision.
// ---------------------------------------------------------------------------
module pe_align_shift
   import pe_align_add_pkg::*;
(
   input  logic [SIG_W-1:0] sig_i,
   input  logic [EXP_W-1:0] dist_i,
   output logic [SIG_W-1:0] shifted_o
`ifdef PE_ALIGN_STICKY_EN
   ,
   output logic             sticky_o
`endif
);

   localparam logic [EXP_W-1:0] MAX_DIST = EXP_W'(SIG_W);

   // Right shift; anything past M+1 positions leaves nothing behind
   always_comb begin
      shifted_o = '0;
      if (dist_i <= MAX_DIST) begin
         shifted_o = sig_i >> dist_i;
      end
   end

`ifdef PE_ALIGN_STICKY_EN
   logic [SIG_W-1:0] lostMask;

   // Mask of the low bits that fall off the end, then OR-reduce them
   always_comb begin
      lostMask = '1;
      if (dist_i <= MAX_DIST) begin
         lostMask = ~({SIG_W{1'b1}} << dist_i);
      end
      sticky_o = |(sig_i & lostMask);
   end
`endif

endmodule

// File: rtl/pe_align_add.sv
// ---------------------------------------------------------------------------
// pe_align_add
// Two-stage floating-point align/add core with valid/ready handshakes.
//   S1: pick the larger-magnitude operand, align the smaller one.
//   S2: add or subtract the aligned significands, handle carry-out and the
//       exact-zero case; result is left unnormalized for the normalizer.
// Optional feature macro: PE_ALIGN_STICKY_EN carries the alignment sticky
// bit through both stages to sticky_out; otherwise sticky_out is tied low.
// ---------------------------------------------------------------------------
module pe_align_add
   import pe_align_add_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             sign_a,
   input  logic             sign_b,
   input  logic [EXP_W-1:0] exp_a,
   input  logic [EXP_W-1:0] exp_b,
   input  logic [SIG_W-1:0] sig_a,
   input  logic [SIG_W-1:0] sig_b,
   input  logic             sub_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             sign_out,
   output logic [EXP_W-1:0] exp_out,
   output logic [SIG_W-1:0] sig_out,
   output logic             zero_out,
   output logic             sticky_out
);

   logic       s1Valid_q;
   s1Bundle_t  s1_q;
   s1Bundle_t  s1_d;
   logic       outValid_q;
   outBundle_t out_q;
   outBundle_t out_d;

   logic       s2Advance;
   logic       s1Advance;

   logic             effSignB;
   logic             effSub;
   logic             bSel;
   logic [EXP_W-1:0] expBig;
   logic [EXP_W-1:0] expSmall;
   logic [EXP_W-1:0] alignDist;
   logic [SIG_W-1:0] sigBig;
   logic [SIG_W-1:0] sigSmall;
   logic [SIG_W-1:0] sigAligned;
`ifdef PE_ALIGN_STICKY_EN
   logic             rawSticky;
`endif

   logic [SIG_W:0]   sum;
   logic [SIG_W-1:0] diff;

   // A stage moves forward when it is empty or the stage after it moves
   assign s2Advance = !outValid_q || out_ready;
   assign s1Advance = s1Valid_q && s2Advance;
   assign in_ready  = !s1Valid_q || s1Advance;

   // Align stage: fold sub_op into b's sign, choose the larger magnitude
   always_comb begin
      effSignB = sign_b ^ sub_op;
      effSub   = sign_a ^ effSignB;
      bSel     = (exp_b > exp_a) || ((exp_b == exp_a) && (sig_b > sig_a));
      expBig   = bSel ? exp_b : exp_a;
      expSmall = bSel ? exp_a : exp_b;
      sigBig   = bSel ? sig_b : sig_a;
      sigSmall = bSel ? sig_a : sig_b;
      alignDist = expBig - expSmall;

      s1_d          = '0;
      s1_d.sign     = bSel ? effSignB : sign_a;
      s1_d.exp      = expBig;
      s1_d.bigSig   = sigBig;
      s1_d.smallSig = sigAligned;
      s1_d.op       = effSub ? OP_SUB : OP_ADD;
`ifdef PE_ALIGN_STICKY_EN
      s1_d.sticky   = rawSticky;
`endif
   end

   pe_align_shift uAlignShift (
      .sig_i     (sigSmall),
      .dist_i    (alignDist),
      .shifted_o (sigAligned)
`ifdef PE_ALIGN_STICKY_EN
      ,
      .sticky_o  (rawSticky)
`endif
   );

   // Add stage: magnitude add with carry handling, or big-minus-small
   always_comb begin
      sum  = {1'b0, s1_q.bigSig} + {1'b0, s1_q.smallSig};
      diff = s1_q.bigSig - s1_q.smallSig;

      out_d      = '0;
      out_d.sign = s1_q.sign;
      out_d.exp  = s1_q.exp;
`ifdef PE_ALIGN_STICKY_EN
      out_d.sticky = s1_q.sticky;
`endif
      if (s1_q.op == OP_ADD) begin
         if (sum[SIG_W]) begin
            out_d.sig = sum[SIG_W:1];
            out_d.exp = expIncSat(s1_q.exp);
`ifdef PE_ALIGN_STICKY_EN
            out_d.sticky = s1_q.sticky | sum[0];
`endif
         end else begin
            out_d.sig = sum[SIG_W-1:0];
         end
      end else begin
         out_d.sig = diff;
      end

`ifdef PE_ALIGN_STICKY_EN
      if ((out_d.sig == '0) && !out_d.sticky) begin
`else
      if (out_d.sig == '0) begin
`endif
         out_d.sign = '0;
         out_d.exp  = '0;
         out_d.zero = 1'b1;
      end
   end

   // Align-stage register: accept a new operand pair whenever there is room
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1Valid_q <= 1'b0;
         s1_q      <= '0;
      end else if (in_ready) begin
         s1Valid_q <= in_valid;
         if (in_valid) begin
            s1_q <= s1_d;
         end
      end
   end

   // Output register: holds the result steady until the consumer takes it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outValid_q <= 1'b0;
         out_q      <= '0;
      end else if (s2Advance) begin
         outValid_q <= s1Valid_q;
         if (s1Valid_q) begin
            out_q <= out_d;
         end
      end
   end

   assign out_valid = outValid_q;
   assign sign_out  = out_q.sign;
   assign exp_out   = out_q.exp;
   assign sig_out   = out_q.sig;
   assign zero_out  = out_q.zero;
`ifdef PE_ALIGN_STICKY_EN
   assign sticky_out = out_q.sticky;
`else
   assign sticky_out = 1'b0;
`endif

endmodule
